// File: rtl/y86_pkg.sv
// Shared Y86-64 pipeline definitions: icodes, status codes and the memory
// stage's state encoding and decoded-op struct.
package y86_pkg;

  localparam logic [3:0] HALT  = 4'h0;
  localparam logic [3:0] NOP   = 4'h1;
  localparam logic [3:0] CMOV  = 4'h2;
  localparam logic [3:0] IRMOV = 4'h3;
  localparam logic [3:0] RMMOV = 4'h4;
  localparam logic [3:0] MRMOV = 4'h5;
  localparam logic [3:0] OPQ   = 4'h6;
  localparam logic [3:0] JXX   = 4'h7;
  localparam logic [3:0] CALL  = 4'h8;
  localparam logic [3:0] RET   = 4'h9;
  localparam logic [3:0] PUSH  = 4'hA;
  localparam logic [3:0] POP   = 4'hB;

  localparam logic [2:0] AOK = 3'd1;
  localparam logic [2:0] HLT = 3'd2;
  localparam logic [2:0] ADR = 3'd3;
  localparam logic [2:0] INS = 3'd4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CHECK  = 2'd1,
    ACCESS = 2'd2,
    HOLD   = 2'd3
  } ma_state_e;

  // addr_sel: 0 = val_e, 1 = val_a; data_sel: 0 = val_a, 1 = val_p
  typedef struct packed {
    logic access;
    logic write;
    logic addr_sel;
    logic data_sel;
  } mem_op_t;

endpackage

// File: rtl/memory_access_if.sv
// Memory-stage bundle: execute-side input handshake, data-memory bus and
// write-back output handshake.
interface memory_access_if;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_code;
  logic [2:0]  in_stat;
  logic [63:0] val_e;
  logic [63:0] val_a;
  logic [63:0] val_p;
  logic        mem_req;
  logic        mem_we;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic        mem_ack;
  logic [63:0] mem_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] val_m;
  logic [2:0]  out_stat;

  modport master (
    input  in_valid, in_code, in_stat, val_e, val_a, val_p,
    input  mem_ack, mem_rdata, out_ready,
    output in_ready, mem_req, mem_we, mem_addr, mem_wdata,
    output out_valid, val_m, out_stat
  );

  modport slave (
    output in_valid, in_code, in_stat, val_e, val_a, val_p,
    output mem_ack, mem_rdata, out_ready,
    input  in_ready, mem_req, mem_we, mem_addr, mem_wdata,
    input  out_valid, val_m, out_stat
  );
endinterface

// File: rtl/memory_access_mem_op_decode.sv
// Maps an icode to the data-memory operation it needs.
module mem_op_decode
  import y86_pkg::*;
(
  input  logic [3:0] code,
  output mem_op_t    op
);

  always_comb begin
    op = '0;
    case (code)
      RMMOV, PUSH: begin op.access = 1'b1; op.write = 1'b1; end
      MRMOV:       op.access = 1'b1;
      CALL:        begin op.access = 1'b1; op.write = 1'b1; op.data_sel = 1'b1; end
      RET, POP:    begin op.access = 1'b1; op.addr_sel = 1'b1; end
      default:     op = '0;
    endcase
  end

endmodule

// File: rtl/memory_access.sv
// Y86 memory stage: decodes the access, range-checks it, runs a req/ack bus
// transaction with timeout, and holds the result for write-back.
module memory_access
  import y86_pkg::*;
#(
  parameter int MEM_BYTES = 8192,
  parameter int TIMEOUT   = 16
) (
  input logic              clock,
  input logic              reset_n,
  memory_access_if.master  bus
);

  localparam int          CW       = $clog2(TIMEOUT) + 1;
  localparam logic [63:0] ADDR_MAX = 64'(MEM_BYTES - 8);

  ma_state_e   state;
  mem_op_t     op;
  logic        acc_q, wr_q;
  logic [2:0]  stat_q;
  logic [63:0] addr_q, wdata_q;
  logic [CW-1:0] cnt;

  logic        in_ready, mem_req, mem_we, out_valid;
  logic [63:0] mem_addr, mem_wdata, val_m;
  logic [2:0]  out_stat;

  mem_op_decode u_dec (.code(bus.in_code), .op(op));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      out_valid <= 1'b0;
      val_m     <= '0;
      out_stat  <= AOK;
      cnt       <= '0;
      acc_q     <= 1'b0;
      wr_q      <= 1'b0;
      stat_q    <= AOK;
      addr_q    <= '0;
      wdata_q   <= '0;
    end else begin
      case (state)
        IDLE: if (bus.in_valid) begin
          acc_q    <= op.access;
          wr_q     <= op.write;
          stat_q   <= bus.in_stat;
          addr_q   <= op.addr_sel ? bus.val_a : bus.val_e;
          wdata_q  <= op.data_sel ? bus.val_p : bus.val_a;
          in_ready <= 1'b0;
          state    <= CHECK;
        end
        CHECK: begin
          if (stat_q != AOK) begin
            out_stat  <= stat_q;
            val_m     <= '0;
            out_valid <= 1'b1;
            state     <= HOLD;
          end else if (!acc_q) begin
            out_stat  <= AOK;
            val_m     <= '0;
            out_valid <= 1'b1;
            state     <= HOLD;
          end else if (addr_q > ADDR_MAX) begin
            // Unsigned compare against size-8 also rejects wrapped addresses.
            out_stat  <= ADR;
            val_m     <= '0;
            out_valid <= 1'b1;
            state     <= HOLD;
          end else begin
            mem_req   <= 1'b1;
            mem_we    <= wr_q;
            mem_addr  <= addr_q;
            mem_wdata <= wdata_q;
            cnt       <= '0;
            state     <= ACCESS;
          end
        end
        ACCESS: begin
          // Ack takes priority over an expiring counter.
          if (bus.mem_ack) begin
            mem_req   <= 1'b0;
            val_m     <= wr_q ? 64'd0 : bus.mem_rdata;
            out_stat  <= AOK;
            out_valid <= 1'b1;
            state     <= HOLD;
          end else if (cnt == CW'(TIMEOUT - 1)) begin
            mem_req   <= 1'b0;
            val_m     <= '0;
            out_stat  <= ADR;
            out_valid <= 1'b1;
            state     <= HOLD;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        HOLD: if (bus.out_ready) begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.mem_req   = mem_req;
  assign bus.mem_we    = mem_we;
  assign bus.mem_addr  = mem_addr;
  assign bus.mem_wdata = mem_wdata;
  assign bus.out_valid = out_valid;
  assign bus.val_m     = val_m;
  assign bus.out_stat  = out_stat;

endmodule

// File: doc/memory_access.md
Name: memory_access

Overview:
- SEQ memory stage; sits directly upstream of write-back.
- Takes execute results (in_code, val_e, val_a, val_p), decides read/write/none, and drives a variable-latency data-memory bus with a req/ack handshake.
- Returns val_m and an updated status to write-back through a single-entry output register.
- Replaces the combinational memory lookup so that multi-cycle memories and address faults are handled explicitly.

Parameters:
- MEM_BYTES, 8192, data memory size in bytes; valid access requires addr + 8 <= MEM_BYTES.
- TIMEOUT, 16, max cycles to wait for mem_ack before the access is flagged ADR.

Ports:
- clock  in  1  stage clock
- reset_n  in  1  asynchronous, active-low reset
- in_valid  in  1  execute result present
- in_ready  out  1  stage can accept a new instruction
- in_code  in  4  icode
- in_stat  in  3  incoming status (1 AOK, 2 HLT, 3 ADR, 4 INS)
- val_e  in  64  ALU result
- val_a  in  64  register A value
- val_p  in  64  next PC
- mem_req  out  1  memory request
- mem_we  out  1  1 = write
- mem_addr  out  64  byte address
- mem_wdata  out  64  write data
- mem_ack  in  1  memory completed request; mem_rdata valid when read
- mem_rdata  in  64  read data
- out_valid  out  1  result valid for write-back
- out_ready  in  1  write-back accepts
- val_m  out  64  loaded value (0 for non-loads)
- out_stat  out  3  final status

Behaviour:
- Reset (async, reset_n=0) forces:
  - state IDLE, in_ready=1, mem_req=0, mem_we=0, out_valid=0.
  - mem_addr, mem_wdata, val_m all 0; out_stat=1 (AOK); timeout counter 0.
- Op decode (registered on accept):
  - 4 rmmovq: write M[val_e]=val_a.
  - 5 mrmovq: read M[val_e].
  - 8 call: write M[val_e]=val_p.
  - 9 ret, 11 popq: read M[val_a].
  - 10 pushq: write M[val_e]=val_a.
  - All other codes: no access.
- States: IDLE, CHECK, ACCESS, HOLD.
- IDLE:
  - in_ready=1.
  - in_valid sampled high: latch inputs and go to CHECK.
- CHECK (1 cycle):
  - in_stat != AOK: pass it through, val_m=0, go to HOLD.
  - No-access op: val_m=0, stat AOK, go to HOLD.
  - Address out of range (addr > MEM_BYTES-8, unsigned 64-bit compare; wrap is never legal): stat ADR, no bus activity, go to HOLD.
  - Otherwise drive mem_req=1, mem_we, mem_addr, mem_wdata; clear counter; go to ACCESS.
- ACCESS:
  - mem_req, mem_we, mem_addr, mem_wdata held stable until mem_ack.
  - mem_ack=1: drop mem_req next cycle. On a read, capture mem_rdata into val_m. Stat AOK. Go to HOLD.
  - Counter increments each cycle without ack. Counter reaching TIMEOUT-1 without ack: drop mem_req, stat ADR, val_m=0, go to HOLD.
  - Ack on the same cycle the counter hits its limit: ack wins, access succeeds.
  - mem_ack outside ACCESS is ignored.
- HOLD:
  - out_valid=1; val_m and out_stat stable.
  - out_ready=1: out_valid drops next cycle and the stage goes to IDLE.
  - HOLD->IDLE costs a cycle; there is no back-to-back accept in the same cycle.
- Latencies:
  - No-access op: accept at cycle 0, out_valid at cycle 2.
  - Memory op with ack in the first ACCESS cycle: out_valid at cycle 3.
- in_ready=0 in every state except IDLE.
- HLT/ADR/INS results keep repeating through the handshake; the stage never blocks on them.
- reset_n deasserted mid-ACCESS: mem_req drops immediately (async) and the pending access is abandoned. A late ack after reset is ignored, because the stage is in IDLE.

Decomposition:
- Shared package y86_pkg holds:
  - icode constants: HALT, NOP, CMOV, IRMOV, RMMOV, MRMOV, OPQ, JXX, CALL, RET, PUSH, POP.
  - stat constants: AOK, HLT, ADR, INS.
  - The 2-bit state encoding for this block.
- Also used by the fetch, decode and write-back stages.
- One natural sub-module, mem_op_decode: combinational mapping of in_code to {access, write, addr_sel, data_sel}. Everything else stays in memory_access.

Test Plan:
- mrmovq: in_code=5, val_e=0x100; memory acks after 2 cycles with 0xDEADBEEF -> mem_we=0, mem_addr=0x100; val_m=0xDEADBEEF, out_stat=1, out_valid in cycle 5.
- pushq: in_code=10, val_e=0x1F8, val_a=0x55; ack in 1 cycle -> mem_we=1, mem_addr=0x1F8, mem_wdata=0x55; val_m=0, stat=1.
- Out-of-range: in_code=4, val_e=MEM_BYTES-7 (and val_e=0xFFFFFFFFFFFFFFF8) -> mem_req never asserted; out_stat=3.
- Timeout: in_code=11, val_a=0x40, ack never given -> mem_req drops after 16 cycles; out_stat=3, val_m=0. Repeat with ack exactly at the last count -> stat=1, data captured.
- Backpressure/pass-through: in_stat=2 with in_code=0, out_ready held 0 for 5 cycles -> out_valid stays 1, val_m=0, out_stat=2, in_ready=0 throughout; accept on release.
- Reset mid-ACCESS: pull reset_n low 1 cycle into ACCESS -> mem_req=0 asynchronously, out_valid=0, in_ready=1. A stray ack afterwards produces no out_valid.
